rsa_core: RTL and testbench

- 8-bit modular-exponentiation engine for a small RSA datapath: computes R = M^E mod N.
- Operands arrive as three serial bytes on a shared input bus, framed by an active-low load strobe.
- The result is presented on an 8-bit output, qualified by a one-cycle done pulse; an error flag flags an illegal modulus.
- Sits between a byte-wide host/loader and a result collector.

---
 rtl/rsa_core.sv | 141 ++++++++++++++
 tb/tb_rsa_core.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rsa_core.sv
// 8-bit constant-time modular exponentiation R = M^E mod N with serial byte loading.
// Left-to-right square-and-always-multiply built on a bit-serial interleaved modular multiplier.
module rsa_core (
    input  logic       core_clk,
    input  logic       core_rst,
    input  logic       core_load,
    input  logic [7:0] core_din,
    output logic       core_done,
    output logic       core_err,
    output logic [7:0] core_dout
);

    typedef enum logic [2:0] {StIdle, StGot1, StGot2, StBusy, StFin} state_e;

    // 8 reduce cycles + 8 exponent bits * (8 square + 8 multiply) cycles
    localparam logic [7:0] LastCnt = 8'd135;

    state_e     state_q, state_d;
    logic [7:0] m_q, m_d, e_q, e_d, n_q, n_d;
    logic [7:0] mr_q, mr_d, r_q, r_d, dout_q, dout_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] acc_q, acc_d;
    logic       done_q, done_d, err_q, err_d;

    logic       reduce_ph, mul_ph, n_ok;
    logic [6:0] k7;
    logic [2:0] bit_idx, exp_idx;
    logic [7:0] op_a, op_b;
    logic [9:0] acc_in, sum, n10, red1, red2;

    // Datapath: one step of MM(op_a, op_b), MSB of op_b first
    always_comb begin
        k7        = cnt_q[6:0] - 7'd8;
        reduce_ph = (cnt_q < 8'd8);
        mul_ph    = k7[3];
        bit_idx   = ~k7[2:0];
        exp_idx   = ~k7[6:4];
        n_ok      = (n_q >= 8'd2);
        op_a      = reduce_ph ? 8'd1 : r_q;
        op_b      = reduce_ph ? m_q : (mul_ph ? mr_q : r_q);
        acc_in    = (k7[2:0] == 3'd0) ? 10'd0 : acc_q;
        n10       = {2'b00, n_q};
        sum       = (acc_in << 1) + (op_b[bit_idx] ? {2'b00, op_a} : 10'd0);
        red1      = (sum >= n10) ? sum - n10 : sum;
        red2      = (red1 >= n10) ? red1 - n10 : red1;
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        e_d     = e_q;
        n_d     = n_q;
        mr_d    = mr_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!core_load) begin
                    m_d     = core_din;
                    state_d = StGot1;
                end
            end
            StGot1: begin
                if (!core_load) begin
                    e_d     = core_din;
                    state_d = StGot2;
                end
            end
            StGot2: begin
                if (!core_load) begin
                    n_d     = core_din;
                    r_d     = 8'd1;
                    cnt_d   = 8'd0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Illegal modulus still burns the full cycle count to keep latency fixed
                if (n_ok) begin
                    acc_d = red2;
                    if (k7[2:0] == 3'd7) begin
                        if (reduce_ph) begin
                            mr_d = red2[7:0];
                        end else if (!mul_ph || e_q[exp_idx]) begin
                            r_d = red2[7:0];
                        end
                    end
                end
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LastCnt) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                err_d   = !n_ok;
                dout_d  = n_ok ? r_q : 8'h00;
                cnt_d   = 8'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rst) begin
        if (!core_rst) begin
            state_q <= StIdle;
            m_q     <= 8'h00;
            e_q     <= 8'h00;
            n_q     <= 8'h00;
            mr_q    <= 8'h00;
            r_q     <= 8'h00;
            cnt_q   <= 8'h00;
            acc_q   <= 10'h000;
            dout_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            n_q     <= n_d;
            mr_q    <= mr_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign core_done = done_q;
    assign core_err  = err_q;
    assign core_dout = dout_q;

endmodule

// File: tb/tb_rsa_core.sv
// Self-checking bench for rsa_core: directed vector table, corner-case sequences,
// and random operands compared against a plain-arithmetic modular exponentiation model.
module tb_rsa_core;

    logic       core_clk = 1'b0;
    logic       core_rst;
    logic       core_load;
    logic [7:0] core_din;
    logic       core_done;
    logic       core_err;
    logic [7:0] core_dout;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int ref_lat  = -1;

    rsa_core dut (
        .core_clk  (core_clk),
        .core_rst  (core_rst),
        .core_load (core_load),
        .core_din  (core_din),
        .core_done (core_done),
        .core_err  (core_err),
        .core_dout (core_dout)
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) if (core_done) done_cnt++;

    typedef struct {
        logic [7:0] m;
        logic [7:0] e;
        logic [7:0] n;
        logic [7:0] dout;
        logic       err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] ref_pow(input int m, input int e, input int n);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * m) % n;
        return r[7:0];
    endfunction

    task automatic run_op(input logic [7:0] m, input logic [7:0] e, input logic [7:0] n,
                          input bit noisy, output logic [7:0] dout, output logic err,
                          output int lat);
        bit got = 0;
        @(negedge core_clk); core_load = 1'b0; core_din = m;
        @(negedge core_clk); core_din = e;
        @(negedge core_clk); core_din = n;
        @(negedge core_clk); core_load = 1'b1; core_din = 8'h00;
        lat = 0;
        while (!got && lat < 300) begin
            if (noisy && (lat == 10 || lat == 60 || lat == 100)) begin
                core_load = 1'b0;
                core_din  = 8'($urandom);
            end else begin
                core_load = 1'b1;
            end
            @(negedge core_clk);
            lat++;
            if (core_done) got = 1;
        end
        core_load = 1'b1;
        dout = core_dout;
        err  = core_err;
        check("done_seen", int'(got), 1);
        @(negedge core_clk);
        check("done_one_cycle", int'(core_done), 0);
        check("err_low_after_done", int'(core_err), 0);
    endtask

    task automatic op_and_check(input string tag, input logic [7:0] m, input logic [7:0] e,
                                input logic [7:0] n, input logic [7:0] xd, input logic xe,
                                input bit noisy);
        logic [7:0] d;
        logic       er;
        int         lat;
        run_op(m, e, n, noisy, d, er, lat);
        check({tag, "_dout"}, int'(d), int'(xd));
        check({tag, "_err"}, int'(er), int'(xe));
        if (ref_lat < 0) ref_lat = lat;
        check({tag, "_latency"}, lat, ref_lat);
        check({tag, "_latency_le150"}, int'(lat <= 150), 1);
    endtask

    initial begin
        int base;
        int bad;
        vecs[0] = '{m: 8'd88,  e: 8'd7,   n: 8'd187, dout: 8'h0B, err: 1'b0};
        vecs[1] = '{m: 8'h0B,  e: 8'd23,  n: 8'd187, dout: 8'h58, err: 1'b0};
        vecs[2] = '{m: 8'd5,   e: 8'd0,   n: 8'd7,   dout: 8'h01, err: 1'b0};
        vecs[3] = '{m: 8'd200, e: 8'd1,   n: 8'd13,  dout: 8'h05, err: 1'b0};
        vecs[4] = '{m: 8'd254, e: 8'd255, n: 8'd255, dout: 8'hFE, err: 1'b0};
        vecs[5] = '{m: 8'd0,   e: 8'd9,   n: 8'd50,  dout: 8'h00, err: 1'b0};
        vecs[6] = '{m: 8'd3,   e: 8'd5,   n: 8'd0,   dout: 8'h00, err: 1'b1};
        vecs[7] = '{m: 8'd3,   e: 8'd5,   n: 8'd1,   dout: 8'h00, err: 1'b1};
        vecs[8] = '{m: 8'd88,  e: 8'd7,   n: 8'd187, dout: 8'h0B, err: 1'b0};

        core_rst  = 1'b0;
        core_load = 1'b1;
        core_din  = 8'h00;
        repeat (5) @(negedge core_clk);
        check("reset_done", int'(core_done), 0);
        check("reset_err", int'(core_err), 0);
        check("reset_dout", int'(core_dout), 0);
        core_rst = 1'b1;
        repeat (10) @(negedge core_clk);
        check("idle_no_done", done_cnt, 0);

        foreach (vecs[i]) begin
            op_and_check($sformatf("vec%0d", i), vecs[i].m, vecs[i].e, vecs[i].n,
                         vecs[i].dout, vecs[i].err, 1'b0);
        end

        bad = 0;
        repeat (20) begin
            @(negedge core_clk);
            if (core_dout !== 8'h0B || core_done !== 1'b0) bad++;
        end
        check("dout_stable_idle", bad, 0);

        // Strobes during BUSY must not disturb the result or the byte counter
        base = done_cnt;
        op_and_check("busy_strobes", 8'd88, 8'd7, 8'd187, 8'h0B, 1'b0, 1'b1);
        op_and_check("after_strobes", 8'd5, 8'd0, 8'd7, 8'h01, 1'b0, 1'b0);
        check("busy_strobes_done_count", done_cnt - base, 2);

        // Reset in the middle of a computation
        @(negedge core_clk); core_load = 1'b0; core_din = 8'd11;
        @(negedge core_clk); core_din = 8'd23;
        @(negedge core_clk); core_din = 8'd187;
        @(negedge core_clk); core_load = 1'b1;
        repeat (40) @(negedge core_clk);
        core_rst = 1'b0;
        #1;
        check("midrst_done", int'(core_done), 0);
        check("midrst_err", int'(core_err), 0);
        check("midrst_dout", int'(core_dout), 0);
        repeat (2) @(negedge core_clk);
        core_rst = 1'b1;
        base = done_cnt;
        repeat (200) @(negedge core_clk);
        check("midrst_no_done", done_cnt - base, 0);
        op_and_check("after_midrst", 8'd11, 8'd23, 8'd187, 8'h58, 1'b0, 1'b0);

        // Back-to-back sets, 10 idle cycles apart
        base = done_cnt;
        op_and_check("b2b_0", 8'd2, 8'd10, 8'd251, ref_pow(2, 10, 251), 1'b0, 1'b0);
        repeat (10) @(negedge core_clk);
        op_and_check("b2b_1", 8'd7, 8'd3, 8'd100, 8'd43, 1'b0, 1'b0);
        repeat (10) @(negedge core_clk);
        check("b2b_done_count", done_cnt - base, 2);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] m, e, n, xd;
            m  = 8'($urandom);
            e  = 8'($urandom);
            n  = (i % 10 == 9) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255));
            xd = (n < 2) ? 8'h00 : ref_pow(int'(m), int'(e), int'(n));
            op_and_check($sformatf("rand%0d", i), m, e, n, xd, n < 2, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
